// File: rtl/logic_sequencer.sv
// Accumulator-based command sequencer driving an external 8-bit logic unit.
// Optional result-consistency checker enabled by defining LOGIC_SEQ_CHECK_EN.
module logic_sequencer #(
  parameter logic [7:0] RESET_ACC   = 8'h00,
  parameter int         COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [7:0]             cmd_data,
  output logic [7:0]             lu_A,
  output logic [7:0]             lu_B,
  output logic [1:0]             lu_sel,
  input  logic [7:0]             lu_result,
  input  logic [3:0]             lu_nzvc,
  output logic [7:0]             acc,
  output logic [3:0]             flags,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] op_count
`ifdef LOGIC_SEQ_CHECK_EN
  ,
  output logic                   err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_LDZ = 3'b101;
  localparam logic [2:0] OP_LDN = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  // N and Z follow the loaded value; V and C are cleared by local loads.
  function automatic logic [3:0] load_flags(input logic [7:0] value);
    return {value[7], (value == 8'h00), 2'b00};
  endfunction

  // A logic unit never produces V/C and its N/Z must match its result.
  function automatic logic nzvc_mismatch(input logic [7:0] res, input logic [3:0] nzvc);
    return (nzvc[1:0] != 2'b00) || (nzvc[2] != (res == 8'h00)) || (nzvc[3] != res[7]);
  endfunction

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             lu_a_q, lu_a_d;
  logic [7:0]             lu_b_q, lu_b_d;
  logic [1:0]             lu_sel_q, lu_sel_d;
  logic [7:0]             acc_q, acc_d;
  logic [3:0]             flags_q, flags_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
`ifdef LOGIC_SEQ_CHECK_EN
  logic                   err_q, err_d;
`endif

  // Next-state and datapath update for the IDLE -> ISSUE -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    lu_a_d   = lu_a_q;
    lu_b_d   = lu_b_q;
    lu_sel_d = lu_sel_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    count_d  = count_q;
`ifdef LOGIC_SEQ_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = ST_ISSUE;
          if (!cmd_op[2]) begin
            lu_a_d   = acc_q;
            lu_b_d   = cmd_data;
            lu_sel_d = cmd_op[1:0];
          end else begin
            lu_a_d   = lu_a_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        case (op_q)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            acc_d   = lu_result;
            flags_d = lu_nzvc;
`ifdef LOGIC_SEQ_CHECK_EN
            err_d   = err_q | nzvc_mismatch(lu_result, lu_nzvc);
`endif
          end
          OP_LD: begin
            acc_d   = data_q;
            flags_d = load_flags(data_q);
          end
          OP_LDZ: begin
            if (flags_q[2]) begin
              acc_d = data_q;
            end else begin
              acc_d = acc_q;
            end
          end
          OP_LDN: begin
            if (flags_q[3]) begin
              acc_d = data_q;
            end else begin
              acc_d = acc_q;
            end
          end
          OP_CLR: begin
            acc_d   = RESET_ACC;
            flags_d = load_flags(RESET_ACC);
          end
          default: begin
            acc_d = acc_q;
          end
        endcase
        count_d = count_q + COUNT_WIDTH'(1);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake and completion strobes are registered from the next state.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'b000;
      data_q   <= 8'h00;
      lu_a_q   <= 8'h00;
      lu_b_q   <= 8'h00;
      lu_sel_q <= 2'b00;
      acc_q    <= RESET_ACC;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= '0;
`ifdef LOGIC_SEQ_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      lu_a_q   <= lu_a_d;
      lu_b_q   <= lu_b_d;
      lu_sel_q <= lu_sel_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
`ifdef LOGIC_SEQ_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign lu_A      = lu_a_q;
  assign lu_B      = lu_b_q;
  assign lu_sel    = lu_sel_q;
  assign acc       = acc_q;
  assign flags     = flags_q;
  assign done      = done_q;
  assign op_count  = count_q;
`ifdef LOGIC_SEQ_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: doc/logic_sequencer.md
Name: logic_sequencer

Overview:
- Accumulator-based command sequencer. It sits upstream of the 8-bit logic unit and drives that unit's A/B/sel inputs.
- It captures the unit's result and NZVC outputs into an architectural accumulator and flag register.
- Commands arrive over a valid/ready handshake. One command completes every 3 cycles.
- Also provides local load, conditional-load and clear operations, plus a completed-command counter.

Parameters:
- RESET_ACC, 8'h00, accumulator value after reset and after CLR.
- COUNT_WIDTH, 8, width of op_count; wraps modulo 2**COUNT_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT, 100 LD, 101 LDZ, 110 LDN, 111 CLR.
- cmd_data  input  8  operand.
- lu_A  output  8  to logic unit A.
- lu_B  output  8  to logic unit B.
- lu_sel  output  2  to logic unit sel.
- lu_result  input  8  from logic unit result.
- lu_nzvc  input  4  from logic unit NZVC, bit 3 = N.
- acc  output  8  accumulator.
- flags  output  4  NZVC flag register, bit 3 = N.
- done  output  1  one-cycle pulse per completed command.
- op_count  output  COUNT_WIDTH  count of completed commands.

Behaviour:
- Reset values: state IDLE, acc=RESET_ACC, flags=4'b0000, lu_A=lu_B=0, lu_sel=0, done=0, op_count=0, cmd_ready=1.
- IDLE state:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at a clock edge: latch op/data; go to ISSUE.
  - When the op is a logic op (cmd_op[2]=0), at that same edge: lu_A<=acc, lu_B<=cmd_data, lu_sel<=cmd_op[1:0].
  - For ops 1xx, the lu_* outputs hold their previous values.
- ISSUE state:
  - cmd_ready=0. lu_* are stable for this full cycle; the combinational logic unit settles.
  - At the end-of-cycle edge, per opcode:
    - Logic op (0xx): acc<=lu_result, flags<=lu_nzvc.
    - LD: acc<=data, flags<={data[7], data==0, 1'b0, 1'b0}.
    - LDZ: if flags[2]=1, acc<=data; else acc unchanged. flags unchanged.
    - LDN: as LDZ, gated by flags[3].
    - CLR: acc<=RESET_ACC, flags<={RESET_ACC[7], RESET_ACC==0, 0, 0}.
    - All opcodes: op_count<=op_count+1 (wraps); state becomes DONE.
- DONE state: cmd_ready=0, done=1 for exactly this cycle; next edge returns to IDLE.
- Latency and throughput:
  - Handshake edge E0; acc/flags updated at E1; done high during cycle E1..E2; cmd_ready high again after E2.
  - Maximum throughput is 1 command per 3 cycles.
- cmd_valid while cmd_ready=0 is ignored; the command must be held by the source until accepted.
- Sequencer-driven values for V/C:
  - NOT uses lu_A=acc; lu_B is still loaded with data, and the logic unit ignores it.
  - V and C come only from lu_nzvc or the local rules above; the sequencer never computes them itself.
- A conditional load whose condition is false still pulses done and increments op_count.
- rst in any state takes priority:
  - The in-flight command is discarded: no done pulse, no acc/flags update.
  - All registers return to reset values on that edge.
- Back-to-back commands: a command held valid through DONE is accepted on the first IDLE cycle.

Optional Feature:
- Macro LOGIC_SEQ_CHECK_EN.
- When defined:
  - Adds output err (1 bit, reset 0).
  - err becomes 1 and stays 1 (sticky until rst) if, at the ISSUE capture edge of a logic op, any of these hold:
    - lu_nzvc[1:0] != 0;
    - lu_nzvc[2] != (lu_result==0);
    - lu_nzvc[3] != lu_result[7].
  - acc/flags still update normally.
- When undefined: no err port and no checking logic.

Test Plan:
- After rst: LD 0xF0 -> done at E1+, acc=F0, flags=1000, op_count=1.
- AND 0x3C with acc=F0 -> lu_A=F0, lu_B=3C, lu_sel=00 during ISSUE; acc=30, flags=0000.
- XOR 0x30 with acc=30 -> acc=00, flags=0100. Then NOT -> acc=FF, flags=1000.
- LDZ 0x55 with flags Z=0 -> acc stays FF, done pulses, op_count increments. After CLR: acc=00, flags=0100; LDZ 0x55 -> acc=55.
- cmd_valid held high for 4 commands -> accepts every 3rd cycle, cmd_ready=0 in ISSUE/DONE. rst asserted in ISSUE -> no done, acc=00, op_count=0.
- COUNT_WIDTH=2, 5 commands -> op_count 1,2,3,0,1. With LOGIC_SEQ_CHECK_EN, a stub logic unit returning nzvc=0001 -> err=1 and stays 1 until rst.
